// File: rtl/sprite_motion.sv
// Per-frame sprite top-left position generator: manual and bounce modes.
// Optional: define SPRITE_MOTION_WRAP_EN to wrap instead of reflect in bounce.
module sprite_motion #(
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 720,
    parameter int WIDTH    = 256,
    parameter int HEIGHT   = 256,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        enable_in,
    input  logic        mode_in,
    input  logic [3:0]  dir_in,
    input  logic [3:0]  speed_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        hit_edge_out,
    output logic        busy_out
);

    localparam int XMAX = SCREEN_W - WIDTH;
    localparam int YMAX = SCREEN_H - HEIGHT;
    localparam logic signed [11:0] XMAX_S  = 12'(XMAX);
    localparam logic signed [10:0] YMAX_S  = 11'(YMAX);
    localparam logic signed [11:0] XWRAP_S = 12'(XMAX + 1);
    localparam logic signed [10:0] YWRAP_S = 11'(YMAX + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC_X = 2'd1;
    localparam logic [1:0] S_CALC_Y = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [10:0] x_q, nx_q, nx_d;
    logic [9:0]  y_q, ny_q, ny_d;
    logic        sx_q, sy_q, nsx_q, nsy_q, nsx_d, nsy_d;
    logic        hitx_q, hity_q, hitx_d, hity_d, hit_q;
    logic        mode_q, en_q;
    logic [3:0]  dir_q, spd_q;
    logic        trigger;

    logic signed [11:0] spd_x, vx, sum_x;
    logic signed [10:0] spd_y, vy, sum_y;

    assign trigger = (hcount_in == 11'(SCREEN_W)) && (vcount_in == 10'(SCREEN_H));
    assign spd_x   = $signed({8'd0, spd_q});
    assign spd_y   = $signed({7'd0, spd_q});

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (trigger) state_d = S_CALC_X;
            S_CALC_X: state_d = S_CALC_Y;
            S_CALC_Y: state_d = S_COMMIT;
            default:  state_d = S_IDLE;
        endcase
    end

    // sx/sy = 1 means moving toward smaller coordinates
    always_comb begin
        vx = 12'sd0;
        if (mode_q) begin
            vx = sx_q ? -spd_x : spd_x;
        end else begin
            case (dir_q[1:0])
                2'b01:   vx = spd_x;
                2'b10:   vx = -spd_x;
                default: vx = 12'sd0;
            endcase
        end
        sum_x  = $signed({1'b0, x_q}) + vx;
        nx_d   = x_q;
        nsx_d  = sx_q;
        hitx_d = 1'b0;
        if (en_q) begin
            if (sum_x < 12'sd0) begin
                hitx_d = 1'b1;
                nx_d   = '0;
                if (mode_q) begin
`ifdef SPRITE_MOTION_WRAP_EN
                    nx_d = 11'(sum_x + XWRAP_S);
`else
                    nsx_d = 1'b0;
`endif
                end
            end else if (sum_x > XMAX_S) begin
                hitx_d = 1'b1;
                nx_d   = 11'(XMAX);
                if (mode_q) begin
`ifdef SPRITE_MOTION_WRAP_EN
                    nx_d = 11'(sum_x - XWRAP_S);
`else
                    nsx_d = 1'b1;
`endif
                end
            end else begin
                nx_d = sum_x[10:0];
            end
        end
    end

    always_comb begin
        vy = 11'sd0;
        if (mode_q) begin
            vy = sy_q ? -spd_y : spd_y;
        end else begin
            case (dir_q[3:2])
                2'b01:   vy = spd_y;
                2'b10:   vy = -spd_y;
                default: vy = 11'sd0;
            endcase
        end
        sum_y  = $signed({1'b0, y_q}) + vy;
        ny_d   = y_q;
        nsy_d  = sy_q;
        hity_d = 1'b0;
        if (en_q) begin
            if (sum_y < 11'sd0) begin
                hity_d = 1'b1;
                ny_d   = '0;
                if (mode_q) begin
`ifdef SPRITE_MOTION_WRAP_EN
                    ny_d = 10'(sum_y + YWRAP_S);
`else
                    nsy_d = 1'b0;
`endif
                end
            end else if (sum_y > YMAX_S) begin
                hity_d = 1'b1;
                ny_d   = 10'(YMAX);
                if (mode_q) begin
`ifdef SPRITE_MOTION_WRAP_EN
                    ny_d = 10'(sum_y - YWRAP_S);
`else
                    nsy_d = 1'b1;
`endif
                end
            end else begin
                ny_d = sum_y[9:0];
            end
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            x_q     <= 11'(X_INIT);
            y_q     <= 10'(Y_INIT);
            nx_q    <= '0;
            ny_q    <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            nsx_q   <= 1'b0;
            nsy_q   <= 1'b0;
            hitx_q  <= 1'b0;
            hity_q  <= 1'b0;
            hit_q   <= 1'b0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            dir_q   <= '0;
            spd_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        mode_q <= mode_in;
                        en_q   <= enable_in;
                        dir_q  <= dir_in;
                        spd_q  <= speed_in;
                        // entering bounce always starts heading down-right
                        if (mode_in && !mode_q) begin
                            sx_q <= 1'b0;
                            sy_q <= 1'b0;
                        end
                    end
                end
                S_CALC_X: begin
                    nx_q   <= nx_d;
                    nsx_q  <= nsx_d;
                    hitx_q <= hitx_d;
                end
                S_CALC_Y: begin
                    ny_q   <= ny_d;
                    nsy_q  <= nsy_d;
                    hity_q <= hity_d;
                end
                default: begin
                    x_q   <= nx_q;
                    y_q   <= ny_q;
                    sx_q  <= nsx_q;
                    sy_q  <= nsy_q;
                    hit_q <= hitx_q | hity_q;
                end
            endcase
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign hit_edge_out = hit_q;
    assign busy_out     = (state_q != S_IDLE);

endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Upstream position generator for the image sprite stage: produces the sprite's top-left x/y position, updated once per video frame.
- Two modes: manual (direction buttons) and bounce (autonomous, reflects off screen edges).
- Updates happen only in vertical blank, so the sprite never tears mid-frame.

Parameters:
SCREEN_W, 1280, active pixels per line
SCREEN_H, 720, active lines per frame
WIDTH, 256, sprite width in pixels
HEIGHT, 256, sprite height in pixels
X_INIT, 0, x position after reset, must be <= XMAX
Y_INIT, 0, y position after reset, must be <= YMAX
Derived: XMAX = SCREEN_W - WIDTH; YMAX = SCREEN_H - HEIGHT.

Ports:
pixel_clk_in  input  1  pixel clock
rst_n_in  input  1  asynchronous reset, active low
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
enable_in  input  1  1 = motion allowed; 0 = hold position
mode_in  input  1  0 = manual, 1 = bounce
dir_in  input  4  {up, down, left, right}, manual mode only
speed_in  input  4  pixels moved per frame per axis, 0..15
x_out  output  11  sprite x, connects to sprite x_in
y_out  output  10  sprite y, connects to sprite y_in
hit_edge_out  output  1  one-cycle pulse when a position was clamped, reflected or wrapped
busy_out  output  1  high while the FSM is outside S_IDLE

Behaviour:
- Reset (async, rst_n_in low) forces the following immediately: x_out=X_INIT, y_out=Y_INIT, sx=sy=positive, mode_q=0, state=S_IDLE, hit_edge_out=0, busy_out=0.
- Trigger: a single-cycle condition hcount_in==SCREEN_W && vcount_in==SCREEN_H, i.e. the first blanking pixel of the frame. Triggers are ignored outside S_IDLE.
- FSM:
  - S_IDLE: wait for trigger, then go to S_CALC_X.
  - S_CALC_X: compute nx, then go to S_CALC_Y.
  - S_CALC_Y: compute ny, then go to S_COMMIT.
  - S_COMMIT: register x_out/y_out, pulse hit_edge_out if any edge event occurred, return to S_IDLE.
  - New position is visible on x_out/y_out 3 cycles after the trigger cycle.
  - busy_out is high in S_CALC_X, S_CALC_Y and S_COMMIT.
- Arithmetic: 12-bit signed for x, 11-bit signed for y; no overflow is possible at these widths.
- enable_in low at trigger: FSM still runs, but nx=x, ny=y, no hit, signs unchanged.
- Manual mode (mode_in=0):
  - Velocity: vx=+speed if right only, -speed if left only, 0 if both or neither. vy uses down(+)/up(-) the same way.
  - n = pos + v, clamped to [0, MAX]; any clamp counts as an edge event.
  - sx/sy are not modified in manual mode.
- Bounce mode (mode_in=1):
  - Velocity: vx = sx ? -speed : +speed, where sx=1 means negative; vy likewise from sy.
  - If n < 0: n=0, sign set positive, edge event.
  - If n > MAX: n=MAX, sign set negative, edge event.
  - Landing exactly on 0 or MAX is not an edge event.
- Mode change: mode_in is sampled at trigger into mode_q. A 0->1 transition at trigger forces sx=sy=positive before the velocity is computed.
- speed_in is sampled at trigger; a speed change keeps the current bounce direction.
- Position range invariant: 0<=x_out<=XMAX, 0<=y_out<=YMAX at all times.
- Reset mid-calculation aborts the pending update; no commit and no hit pulse.

Optional Feature:
SPRITE_MOTION_WRAP_EN
- Defined: in bounce mode, out-of-range positions wrap instead of reflecting, and signs never change.
  - n > MAX: n -= MAX+1.
  - n < 0: n += MAX+1.
  - hit_edge_out still pulses on a wrap.
- Manual mode is unaffected (still clamps).
- Undefined: reflect behaviour as specified above.

Test Plan:
1. X_INIT=100, Y_INIT=50; assert reset, sweep hcount/vcount without reaching the trigger -> x_out=100, y_out=50, busy_out=0 throughout.
2. Manual mode, dir=right, speed=4, enable=1; trigger at (1280,720) -> 3 cycles later x_out=104, y_out=50, no hit. Repeat with dir=left+right -> x_out unchanged.
3. Bounce mode, x=1022, sx positive, speed=4; trigger -> x_out=1024, hit pulse for 1 cycle. Next frame -> x_out=1020, no hit.
4. Bounce mode, y=2, sy negative, speed=5; trigger -> y_out=0, hit pulse. Next frame -> y_out=5. With SPRITE_MOTION_WRAP_EN defined, the same stimulus -> y_out=462 (YMAX=464, since -3+465=462).
5. Manual then switch mode_in to 1 with speed=3 from x=200, y=200 -> first bounce frame gives x_out=203, y_out=203. Then set enable_in=0 for 2 frames -> x_out/y_out hold, busy_out still pulses for 3 cycles per frame.
6. Drive rst_n_in low one cycle after a trigger (state S_CALC_X) -> outputs return to init immediately, hit_edge_out stays 0, no later commit occurs.
